ball_engine: RTL and testbench

- Multi-ball sprite engine for the VGA path. Holds position, velocity, radius and colour for NUM_BALLS balls.
- Updates every ball's position once per frame, bouncing each ball off the screen edges.
- Renders the current pixel through a 2-stage pipeline from the VGA timing counters. Sits between the VGA timing generator and the RGB pins; a controller programs the balls through a simple write port.

---
 rtl/ball_engine.sv | 142 ++++++++++++++
 tb/tb_ball_engine.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// ball_engine: multi-ball sprite engine with per-frame edge-bounce motion and a 2-stage pixel render pipeline
module ball_engine #(
    parameter int NUM_BALLS    = 4,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int RADIUS_W     = 3,
    parameter int RADIUS_SCALE = 5,
    parameter int VEL_W        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_tick,
    input  logic [11:0]         hcounter,
    input  logic [10:0]         vcounter,
    input  logic                visible,
    input  logic                cfg_we,
    input  logic [2:0]          cfg_idx,
    input  logic [10:0]         cfg_x,
    input  logic [10:0]         cfg_y,
    input  logic [VEL_W-1:0]    cfg_vx,
    input  logic [VEL_W-1:0]    cfg_vy,
    input  logic [RADIUS_W-1:0] cfg_radius,
    input  logic [1:0]          cfg_color,
    output logic                VGA_R,
    output logic                VGA_G,
    output logic                VGA_B,
    output logic                hit,
    output logic [2:0]          hit_idx
);
    localparam int RW = RADIUS_W + 3;

    logic [10:0]         x   [NUM_BALLS];
    logic [10:0]         y   [NUM_BALLS];
    logic [VEL_W-1:0]    vx  [NUM_BALLS];
    logic [VEL_W-1:0]    vy  [NUM_BALLS];
    logic [RADIUS_W-1:0] rad [NUM_BALLS];
    logic [1:0]          col [NUM_BALLS];
    logic signed [12:0]  dx  [NUM_BALLS];
    logic signed [12:0]  dy  [NUM_BALLS];
    logic                vis1;

    logic [NUM_BALLS-1:0]         en;
    logic [NUM_BALLS-1:0]         hit_v;
    logic [NUM_BALLS-1:0][RW-1:0] r_px;
    logic [NUM_BALLS-1:0][11:0]   mx;
    logic [NUM_BALLS-1:0][11:0]   my;
    logic [2:0]                   win;
    logic [1:0]                   wc;
    logic                         any;

    // Returns {bounced, new position}; position is clamped to [r, lim-1-r].
    function automatic logic [11:0] bounce(input logic [10:0] p, input logic [VEL_W-1:0] v,
                                           input logic [RW-1:0] r, input int lim);
        logic signed [12:0] n, lo, hi;
        n  = $signed({2'b00, p}) + $signed({{(13-VEL_W){v[VEL_W-1]}}, v});
        lo = $signed(13'(r));
        hi = 13'(lim - 1) - lo;
        bounce = n < lo ? {1'b1, lo[10:0]} : n > hi ? {1'b1, hi[10:0]} : {1'b0, n[10:0]};
    endfunction

    for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ball
        logic signed [25:0] dxe, dye;
        logic [25:0]        dx2, dy2, r2;
        logic [26:0]        d2;
        assign en[i]   = rad[i] != '0 && col[i] != 2'd0;
        assign r_px[i] = RW'(rad[i]) * RW'(RADIUS_SCALE);
        assign mx[i]   = bounce(x[i], vx[i], r_px[i], H_RES);
        assign my[i]   = bounce(y[i], vy[i], r_px[i], V_RES);
        assign dxe     = {{13{dx[i][12]}}, dx[i]};
        assign dye     = {{13{dy[i][12]}}, dy[i]};
        assign dx2     = dxe * dxe;
        assign dy2     = dye * dye;
        assign r2      = 26'(r_px[i]) * 26'(r_px[i]);
        assign d2      = {1'b0, dx2} + {1'b0, dy2};
        assign hit_v[i] = en[i] && d2 <= {1'b0, r2};
    end

    // Scan from the top so the lowest hitting index is left standing.
    always_comb begin
        win = '0;
        wc  = '0;
        any = 1'b0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (hit_v[i]) begin
                win = 3'(i);
                wc  = col[i];
                any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                x[i]   <= '0;
                y[i]   <= '0;
                vx[i]  <= '0;
                vy[i]  <= '0;
                rad[i] <= '0;
                col[i] <= '0;
                dx[i]  <= '0;
                dy[i]  <= '0;
            end
            vis1 <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (cfg_we && cfg_idx == 3'(i)) begin
                    x[i]   <= cfg_x;
                    y[i]   <= cfg_y;
                    vx[i]  <= cfg_vx;
                    vy[i]  <= cfg_vy;
                    rad[i] <= cfg_radius;
                    col[i] <= cfg_color;
                end else if (frame_tick && en[i]) begin
                    x[i]  <= mx[i][10:0];
                    y[i]  <= my[i][10:0];
                    vx[i] <= mx[i][11] ? -vx[i] : vx[i];
                    vy[i] <= my[i][11] ? -vy[i] : vy[i];
                end
                dx[i] <= $signed({1'b0, hcounter}) - $signed({2'b00, x[i]});
                dy[i] <= $signed({2'b00, vcounter}) - $signed({2'b00, y[i]});
            end
            vis1 <= visible;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            VGA_R   <= 1'b0;
            VGA_G   <= 1'b0;
            VGA_B   <= 1'b0;
            hit     <= 1'b0;
            hit_idx <= '0;
        end else begin
            VGA_R   <= vis1 && any && wc == 2'd1;
            VGA_G   <= vis1 && any && wc == 2'd2;
            VGA_B   <= vis1 && any && wc == 2'd3;
            hit     <= vis1 && any;
            hit_idx <= vis1 && any ? win : 3'd0;
        end
    end
endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: randomized scoreboard bench for ball_engine against a plain-arithmetic ball model
module tb_ball_engine;
    localparam int NB = 4;
    localparam int HR = 640;
    localparam int VR = 480;
    localparam int RS = 5;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_tick = 1'b0;
    logic [11:0]   hcounter = '0;
    logic [10:0]   vcounter = '0;
    logic          visible = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_idx = '0;
    logic [10:0]   cfg_x = '0;
    logic [10:0]   cfg_y = '0;
    logic [VW-1:0] cfg_vx = '0;
    logic [VW-1:0] cfg_vy = '0;
    logic [2:0]    cfg_radius = '0;
    logic [1:0]    cfg_color = '0;
    logic          VGA_R, VGA_G, VGA_B, hit;
    logic [2:0]    hit_idx;
    logic [6:0]    outs;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int mx[NB], my[NB], mvx[NB], mvy[NB], mr[NB], mc[NB];

    typedef struct {int due; logic [6:0] exp; int h; int v;} exp_t;
    typedef struct {int p; int v;} pv_t;
    exp_t q[$];
    exp_t e;

    ball_engine dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .hcounter(hcounter),
        .vcounter(vcounter), .visible(visible), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
        .cfg_radius(cfg_radius), .cfg_color(cfg_color), .VGA_R(VGA_R), .VGA_G(VGA_G),
        .VGA_B(VGA_B), .hit(hit), .hit_idx(hit_idx)
    );

    assign outs = {VGA_R, VGA_G, VGA_B, hit, hit_idx};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL pix_missed h=%0d v=%0d exp=%b", e.h, e.v, e.exp);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            compared++;
            if (outs !== e.exp) begin
                mismatched++;
                $display("FAIL pix h=%0d v=%0d got RGB/hit/idx=%b exp=%b", e.h, e.v, outs, e.exp);
            end
        end
    end

    function automatic int neg(int v);
        int n;
        n = -v;
        if (n > (1 << (VW - 1)) - 1) n -= 1 << VW;
        return n;
    endfunction

    function automatic int sext(logic [VW-1:0] v);
        return v[VW-1] ? int'(v) - (1 << VW) : int'(v);
    endfunction

    function automatic pv_t axis(int p, int v, int r, int lim);
        pv_t o;
        int n;
        n = p + v;
        o.p = n;
        o.v = v;
        if (n < r) begin o.p = r; o.v = neg(v); end
        else if (n > lim - 1 - r) begin o.p = lim - 1 - r; o.v = neg(v); end
        return o;
    endfunction

    function automatic logic [6:0] model_pix(int h, int v);
        int rr, ddx, ddy;
        for (int i = 0; i < NB; i++) begin
            if (mr[i] != 0 && mc[i] != 0) begin
                rr  = mr[i] * RS;
                ddx = h - mx[i];
                ddy = v - my[i];
                if (ddx * ddx + ddy * ddy <= rr * rr)
                    return {mc[i] == 1, mc[i] == 2, mc[i] == 3, 1'b1, 3'(i)};
            end
        end
        return 7'd0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0; mr[i] = 0; mc[i] = 0;
        end
    endtask

    task automatic chk(string name, logic [6:0] got, logic [6:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle (caller has already waited for the edge) and updates the model.
    task automatic drive(logic we, logic tick, int h, int v, logic vis);
        int hh, vv, k;
        pv_t a;
        hh = h & 12'hfff;
        vv = v & 11'h7ff;
        cfg_we = we;
        frame_tick = tick;
        hcounter = 12'(hh);
        vcounter = 11'(vv);
        visible = vis;
        q.push_back('{cyc + 2, vis ? model_pix(hh, vv) : 7'd0, hh, vv});
        if (tick) begin
            for (int i = 0; i < NB; i++) begin
                if (mr[i] != 0 && mc[i] != 0 && !(we && int'(cfg_idx) == i)) begin
                    a = axis(mx[i], mvx[i], mr[i] * RS, HR);
                    mx[i] = a.p; mvx[i] = a.v;
                    a = axis(my[i], mvy[i], mr[i] * RS, VR);
                    my[i] = a.p; mvy[i] = a.v;
                end
            end
        end
        if (we && int'(cfg_idx) < NB) begin
            k = int'(cfg_idx);
            mx[k] = int'(cfg_x); my[k] = int'(cfg_y);
            mvx[k] = sext(cfg_vx); mvy[k] = sext(cfg_vy);
            mr[k] = int'(cfg_radius); mc[k] = int'(cfg_color);
        end
    endtask

    task automatic set_cfg(int idx, int x, int y, int vx, int vy, int r, int c);
        cfg_idx = 3'(idx); cfg_x = 11'(x); cfg_y = 11'(y);
        cfg_vx = VW'(vx); cfg_vy = VW'(vy); cfg_radius = 3'(r); cfg_color = 2'(c);
    endtask

    task automatic wr(int idx, int x, int y, int vx, int vy, int r, int c);
        edge_wait();
        set_cfg(idx, x, y, vx, vy, r, c);
        drive(1'b1, 1'b0, $urandom_range(0, 799), $urandom_range(0, 524), 1'b0);
    endtask

    task automatic wr_tk(int idx, int x, int y, int vx, int vy, int r, int c);
        edge_wait();
        set_cfg(idx, x, y, vx, vy, r, c);
        drive(1'b1, 1'b1, $urandom_range(0, 799), $urandom_range(0, 524), 1'b0);
    endtask

    task automatic tk();
        edge_wait();
        drive(1'b0, 1'b1, $urandom_range(0, 799), $urandom_range(0, 524), 1'b0);
    endtask

    task automatic px(int h, int v);
        edge_wait();
        drive(1'b0, 1'b0, h, v, 1'b1);
    endtask

    task automatic idle();
        edge_wait();
        drive(1'b0, 1'b0, $urandom_range(0, 799), $urandom_range(0, 524), 1'b0);
    endtask

    task automatic probe(int i);
        int r;
        r = mr[i] * RS;
        px(mx[i], my[i]);
        px(mx[i] + r, my[i]);
        px(mx[i] + r + 1, my[i]);
        px(mx[i] - r, my[i]);
        px(mx[i] - r - 1, my[i]);
        px(mx[i], my[i] + r);
        px(mx[i], my[i] - r - 1);
    endtask

    initial begin
        model_clear();
        #2;
        chk("reset_outputs", outs, 7'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int v = 0; v < VR; v += 16)
            for (int h = 0; h < HR; h += 16)
                px(h, v);
        repeat (4) idle();

        wr(0, 100, 100, 0, 0, 2, 1);
        px(110, 100);
        px(111, 100);
        px(107, 107);
        px(100, 100);
        probe(0);

        wr(2, 100, 100, 0, 0, 1, 3);
        wr(0, 100, 100, 0, 0, 1, 1);
        px(100, 100);
        wr(0, 100, 100, 0, 0, 0, 1);
        px(100, 100);
        probe(2);
        wr(2, 0, 0, 0, 0, 0, 0);

        wr(1, 625, 240, 7, 0, 2, 1);
        tk();
        probe(1);
        tk();
        probe(1);

        wr(3, 320, 12, 0, -5, 2, 2);
        tk();
        probe(3);
        wr(3, 320, 12, 0, -2, 2, 2);
        tk();
        probe(3);
        tk();
        probe(3);

        wr(1, 200, 240, 3, 0, 2, 2);
        wr_tk(0, 300, 300, 0, 0, 2, 1);
        probe(0);
        probe(1);
        wr(5, 400, 400, 0, 0, 7, 1);
        px(400, 400);
        wr(2, 500, 100, 1, 1, 4, 0);
        px(500, 100);

        repeat (300) begin
            case ($urandom_range(0, 5))
                0: wr($urandom_range(0, 7), $urandom_range(0, 639), $urandom_range(0, 479),
                      int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                      $urandom_range(0, 7), $urandom_range(0, 3));
                1: tk();
                2, 3: probe($urandom_range(0, NB - 1));
                4: px($urandom_range(0, 639), $urandom_range(0, 479));
                default: idle();
            endcase
        end

        wr(0, 320, 240, 0, 0, 7, 2);
        px(320, 240);
        px(320, 240);
        px(320, 240);
        edge_wait();
        chk("pre_reset_hit", outs, 7'b0101000);
        rst_n = 1'b0;
        #1;
        chk("reset_async", outs, 7'd0);
        q.delete();
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        px(320, 240);
        px(320, 240);
        px(320, 240);

        repeat (4) idle();
        repeat (3) @(posedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
